// File: rtl/gemm_pkg.sv
// Shared GEMM controller types: command header layout, opcodes,
// per-op payload lengths and the command parser error codes.
package gemm_pkg;

  localparam int cmd_buf_width_gp = 32;

  localparam logic [7:0] cmd_op_fetch_gp = 8'hF0;
  localparam logic [7:0] cmd_op_store_gp = 8'hF1;
  localparam logic [7:0] cmd_op_tile_gp  = 8'hF2;
  localparam logic [7:0] cmd_op_wait_gp  = 8'hF3;
  localparam logic [7:0] cmd_op_sync_gp  = 8'hF4;

  localparam logic [7:0] cmd_fetch_len_gp = 8'd12;
  localparam logic [7:0] cmd_store_len_gp = 8'd12;
  localparam logic [7:0] cmd_tile_len_gp  = 8'd12;
  localparam logic [7:0] cmd_wait_len_gp  = 8'd4;
  localparam logic [7:0] cmd_sync_len_gp  = 8'd4;

  typedef enum logic [1:0] {
    cmd_err_none    = 2'd0,
    cmd_err_bad_op  = 2'd1,
    cmd_err_bad_len = 2'd2,
    cmd_err_seq     = 2'd3
  } cmd_parser_err_e;

  typedef struct packed {
    logic [7:0] rsvd;
    logic [7:0] len;
    logic [7:0] id;
    logic [7:0] op;
  } cmd_header_s;

  // Zero marks an opcode the parser does not recognise.
  function automatic logic [7:0] cmd_payload_len(input logic [7:0] op);
    logic [7:0] len;
    len = '0;
    unique case (1'b1)
      op == cmd_op_fetch_gp: len = cmd_fetch_len_gp;
      op == cmd_op_store_gp: len = cmd_store_len_gp;
      op == cmd_op_tile_gp:  len = cmd_tile_len_gp;
      op == cmd_op_wait_gp:  len = cmd_wait_len_gp;
      op == cmd_op_sync_gp:  len = cmd_sync_len_gp;
      default:               len = '0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/gemm_cmd_parser.sv
// Command word parser: header/payload split, validation, decoded output.
// Optional id sequence check: GEMM_CMD_PARSER_SEQ_CHECK_EN.
module gemm_cmd_parser
  import gemm_pkg::*;
#(
  parameter int word_width_p        = cmd_buf_width_gp,
  parameter int max_payload_words_p = 4,
  parameter int op_width_p          = 8,
  parameter int id_width_p          = 8,
  parameter int len_width_p         = 8,
  parameter int err_cnt_width_p     = 16
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic                                        cmd_v_i,
  input  logic [word_width_p-1:0]                     cmd_data_i,
  output logic                                        cmd_ready_o,
  output logic                                        dec_v_o,
  input  logic                                        dec_ready_i,
  output logic [op_width_p-1:0]                       dec_op_o,
  output logic [id_width_p-1:0]                       dec_id_o,
  output logic [len_width_p-1:0]                      dec_len_o,
  output logic [max_payload_words_p*word_width_p-1:0] dec_payload_o,
  output logic                                        err_v_o,
  output logic [1:0]                                  err_code_o,
  output logic [err_cnt_width_p-1:0]                  err_cnt_o
);

  localparam int cnt_w_lp = len_width_p + 1;

  typedef enum logic [1:0] {S_HDR, S_PAY, S_OUT, S_DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
  logic [cnt_w_lp-1:0]        words_q, words_d;
  logic [max_payload_words_p-1:0][word_width_p-1:0] payload_q, payload_d;
  logic                       cmd_ready_q, cmd_ready_d;
  logic                       dec_v_q, dec_v_d;
  logic [op_width_p-1:0]      op_q, op_d;
  logic [id_width_p-1:0]      id_q, id_d;
  logic [len_width_p-1:0]     len_q, len_d;
  logic                       err_v_q, err_v_d;
  cmd_parser_err_e            err_code_q, err_code_d;
  logic [err_cnt_width_p-1:0] err_cnt_q, err_cnt_d;
`ifdef GEMM_CMD_PARSER_SEQ_CHECK_EN
  logic [id_width_p-1:0]      exp_id_q, exp_id_d;
`endif

  cmd_header_s            hdr;
  logic [len_width_p-1:0] hdr_len;
  logic [len_width_p-1:0] exp_len;
  logic [cnt_w_lp-1:0]    hdr_words;
  logic                   op_known;
  logic                   hdr_bad;
  logic                   accept;
  logic                   err_raise;
  logic                   unused_rsvd;
  cmd_parser_err_e        err_sel;

  assign hdr         = cmd_header_s'(cmd_data_i[31:0]);
  assign hdr_len     = len_width_p'(hdr.len);
  assign exp_len     = len_width_p'(cmd_payload_len(hdr.op));
  assign op_known    = (exp_len != '0);
  assign hdr_bad     = !op_known || (hdr_len != exp_len);
  assign hdr_words   = (cnt_w_lp'(hdr_len) + cnt_w_lp'(3)) >> 2;
  assign accept      = cmd_v_i & cmd_ready_q;
  assign unused_rsvd = ^hdr.rsvd;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    words_d     = words_q;
    payload_d   = payload_q;
    cmd_ready_d = cmd_ready_q;
    dec_v_d     = dec_v_q;
    op_d        = op_q;
    id_d        = id_q;
    len_d       = len_q;
    err_raise   = 1'b0;
    err_sel     = cmd_err_none;
    err_v_d     = 1'b0;
    err_code_d  = err_code_q;
    err_cnt_d   = err_cnt_q;
`ifdef GEMM_CMD_PARSER_SEQ_CHECK_EN
    exp_id_d    = exp_id_q;
`endif
    unique case (state_q)
      S_HDR: begin
        if (accept) begin
          payload_d = '0;
          if (hdr_bad) begin
            err_raise = 1'b1;
            if (op_known) err_sel = cmd_err_bad_len;
            else          err_sel = cmd_err_bad_op;
            // Skip the payload so the next header stays aligned.
            if (hdr_words != '0) begin
              state_d = S_DRAIN;
              cnt_d   = hdr_words;
            end
          end else begin
            op_d    = op_width_p'(hdr.op);
            id_d    = id_width_p'(hdr.id);
            len_d   = hdr_len;
            words_d = hdr_words;
            cnt_d   = '0;
            state_d = S_PAY;
`ifdef GEMM_CMD_PARSER_SEQ_CHECK_EN
            if (id_width_p'(hdr.id) != exp_id_q) begin
              err_raise = 1'b1;
              err_sel   = cmd_err_seq;
            end
            exp_id_d = id_width_p'(hdr.id) + id_width_p'(1);
`endif
          end
        end
      end
      S_PAY: begin
        if (accept) begin
          for (int k = 0; k < max_payload_words_p; k++) begin
            if (cnt_q == cnt_w_lp'(k)) payload_d[k] = cmd_data_i;
          end
          cnt_d = cnt_q + cnt_w_lp'(1);
          if (cnt_d == words_q) begin
            state_d     = S_OUT;
            dec_v_d     = 1'b1;
            cmd_ready_d = 1'b0;
          end
        end
      end
      S_OUT: begin
        if (dec_ready_i) begin
          state_d     = S_HDR;
          dec_v_d     = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (accept) begin
          cnt_d = cnt_q - cnt_w_lp'(1);
          if (cnt_q == cnt_w_lp'(1)) state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
    if (err_raise) begin
      err_v_d    = 1'b1;
      err_code_d = err_sel;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + err_cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_HDR;
      cnt_q       <= '0;
      words_q     <= '0;
      payload_q   <= '0;
      cmd_ready_q <= 1'b1;
      dec_v_q     <= 1'b0;
      op_q        <= '0;
      id_q        <= '0;
      len_q       <= '0;
      err_v_q     <= 1'b0;
      err_code_q  <= cmd_err_none;
      err_cnt_q   <= '0;
`ifdef GEMM_CMD_PARSER_SEQ_CHECK_EN
      exp_id_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      payload_q   <= payload_d;
      cmd_ready_q <= cmd_ready_d;
      dec_v_q     <= dec_v_d;
      op_q        <= op_d;
      id_q        <= id_d;
      len_q       <= len_d;
      err_v_q     <= err_v_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
`ifdef GEMM_CMD_PARSER_SEQ_CHECK_EN
      exp_id_q    <= exp_id_d;
`endif
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign dec_v_o       = dec_v_q;
  assign dec_op_o      = op_q;
  assign dec_id_o      = id_q;
  assign dec_len_o     = len_q;
  assign dec_payload_o = payload_q;
  assign err_v_o       = err_v_q;
  assign err_code_o    = err_code_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: doc/gemm_cmd_parser.md
Name: gemm_cmd_parser

Overview:
- Parametrised command-word parser between the 32-bit command FIFO and the master controller's dispatch logic.
- Consumes a stream of command words and splits each command into a header (op, id, len) and a payload of up to max_payload_words_p words.
- Validates the opcode and length against the per-op payload size.
- Emits one decoded command per handshake. Malformed commands are reported and discarded without losing stream alignment.

Parameters:
- word_width_p, 32, width of one command word (= cmd_buf_width_gp)
- max_payload_words_p, 4, payload capacity in words (current widest op uses 3)
- op_width_p, 8, opcode field width
- id_width_p, 8, command id width
- len_width_p, 8, header len field width (payload length in bytes)
- err_cnt_width_p, 16, width of the saturating error counter

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cmd_v_i  in  1  input word valid
- cmd_data_i  in  word_width_p  input command word
- cmd_ready_o  out  1  input word accepted when cmd_v_i & cmd_ready_o
- dec_v_o  out  1  decoded command valid
- dec_ready_i  in  1  consumer accepts the decoded command
- dec_op_o  out  op_width_p  opcode
- dec_id_o  out  id_width_p  command id
- dec_len_o  out  len_width_p  payload byte length
- dec_payload_o  out  max_payload_words_p*word_width_p  payload; word k occupies bits [k*W+W-1:k*W]
- err_v_o  out  1  one-cycle pulse for a malformed command
- err_code_o  out  2  0=none, 1=bad_op, 2=bad_len, 3=seq (optional feature)
- err_cnt_o  out  err_cnt_width_p  saturating count of errors

Behaviour:
- Clock/reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values: state=S_HDR, cmd_ready_o=1, dec_v_o=0, all dec_* fields=0, payload=0, err_v_o=0, err_code_o=0, err_cnt_o=0. Reset mid-command discards the partial command; no output is produced for it.
- Header decode follows the header layout: op=[7:0], id=[15:8], len=[23:16], bits [31:24] ignored.
- Expected payload bytes per op:
  - F0, F1, F2: 12
  - F3, F4: 4
  - any other op: bad_op
- Word count: words = ceil(len/4); len and expected length are compared for exact equality.
- S_HDR (cmd_ready_o=1), on header accept:
  - Clear the payload register.
  - Known op, len matches, len>0: go to S_PAY with cnt=0.
  - Known op, len mismatch: err bad_len. If words>0 go to S_DRAIN with words to skip, else stay in S_HDR.
  - Unknown op: err bad_op, drain ceil(len/4) words the same way.
- S_PAY (cmd_ready_o=1):
  - Each accepted word is written to payload slot cnt, then cnt increments.
  - After the last word is accepted, go to S_OUT; dec_v_o=1 on the next cycle.
- S_OUT:
  - cmd_ready_o=0; dec_v_o=1 with all fields stable until dec_ready_i.
  - On handshake: dec_v_o=0 next cycle; go to S_HDR.
  - Minimum cost of a 12-byte command is 5 cycles (header, 3 payload, 1 out).
- S_DRAIN (cmd_ready_o=1): accept and drop words until the skip count reaches 0, then go to S_HDR. dec_v_o stays 0.
- Bubbles: cmd_v_i low in any state stalls with no state change.
- len exceeding max_payload_words_p*4 is always bad_len, because every legal op is smaller.
- Error reporting:
  - err_v_o pulses on the cycle after the offending header is accepted; err_code_o holds the last code until the next error.
  - err_cnt_o increments per error and saturates at all-ones.

Optional Feature:
- Macro: GEMM_CMD_PARSER_SEQ_CHECK_EN.
- When defined:
  - Track expected_id, reset value 0. Each accepted command's id must equal expected_id.
  - On mismatch: still decode and emit the command, but pulse err_v_o with code 3 and count it.
  - After any valid-op header, expected_id = id+1 modulo 2^id_width_p, so 0xFF wraps to 0x00.
  - bad_op/bad_len takes priority over seq; expected_id is not updated on those.
- When undefined: no id tracking; code 3 is never produced.

Decomposition:
- Into gemm_pkg:
  - cmd_parser_err_e enum (none/bad_op/bad_len/seq).
  - A function cmd_payload_len(op) returning the expected bytes, derived from the existing cmd_*_len_gp constants.
  - Header field offsets reuse cmd_header_s.
- No sub-module; a single FSM plus payload register file.

Test Plan:
- Tile command: header 0x000C_01F2 plus words A,B,C → one dec_v_o with op=F2, id=01, len=12, payload = {0,C,B,A}; cmd_ready_o low until dec_ready_i.
- Back-pressure: hold dec_ready_i=0 for 10 cycles → outputs stable, cmd_ready_o=0, no input words consumed; release → next header accepted the cycle after.
- Bad op: header 0x0008_0277 plus 2 words, then a valid wait 0x0004_03F3 plus 1 word → err bad_op and err_cnt=1; the wait command is decoded correctly.
- Bad len: fetch header with len=8 plus 2 words → err bad_len, both words drained, no dec_v_o. With len=0 → err, no drain.
- Reset mid-payload after 1 of 3 words → no output; next command decodes normally.
- With GEMM_CMD_PARSER_SEQ_CHECK_EN, ids 0,1,3 → third command still emitted, err code 3. Ids FF then 00 → no error.
